// File: rtl/ifu_pkg.sv
// Shared types and default widths for the IFU fetch queue.
package ifu_pkg;

   localparam int ADDR_W_DEF = 48;
   localparam int DATA_W_DEF = 128;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } fq_state_t;

   // Layout of one buffered line at the default widths: data above pc.
   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic [ADDR_W_DEF-1:0] pc;
   } line_entry_t;

endpackage

// File: rtl/ifu_line_fifo.sv
// Line buffer: registered push, combinational head, flush clears pointers; zero-latency pop.
// Caller guarantees no push into a full buffer unless a pop happens in the same cycle.
module ifu_line_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_pop;

   assign do_pop = pop && (count != '0);
   // Head reads as zero when empty so the output bus is quiet out of reset.
   assign head   = (count != '0) ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ifu_fetch_queue.sv
// Sequential line prefetcher: issues AR fetches under credit, buffers returned lines with their PC.
// AR two cycles after enable, R beat visible at output next cycle; issue stalls once buffer + in-flight reaches DEPTH.
module ifu_fetch_queue
   import ifu_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int DEPTH   = 4,
   parameter int MAX_OUT = 2,
   parameter int PC_STEP = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [ADDR_W-1:0]      initial_pc,
   input  logic                   redirect_valid,
   input  logic [ADDR_W-1:0]      redirect_pc,
   output logic [ADDR_W-1:0]      bus_ar,
   output logic                   bus_ar_valid,
   input  logic                   bus_ar_ready,
   input  logic                   bus_r_valid,
   output logic                   bus_r_ready,
   input  logic [DATA_W-1:0]      bus_r_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [ADDR_W-1:0]      out_pc,
   output logic [$clog2(DEPTH):0] occupancy
);
   localparam int OCC_W   = $clog2(DEPTH) + 1;
   localparam int PCI_W   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int ENTRY_W = DATA_W + ADDR_W;

   fq_state_t          state;
   fq_state_t          state_nxt;
   logic [ADDR_W-1:0]  pc;
   logic [OCC_W-1:0]   outstanding;
   logic [OCC_W-1:0]   outstanding_nxt;
   logic [ADDR_W-1:0]  pc_fifo [MAX_OUT];
   logic [PCI_W-1:0]   pcf_wr;
   logic [PCI_W-1:0]   pcf_rd;
   logic               ar_hs;
   logic               r_hs;
   logic               out_hs;
   logic               credit_ok;
   logic               issue;
   logic               track_ar;
   logic               keep_beat;
   logic [ENTRY_W-1:0] head;

   function automatic logic [PCI_W-1:0] pcf_inc(input logic [PCI_W-1:0] p);
      return (p == PCI_W'(MAX_OUT - 1)) ? '0 : p + PCI_W'(1);
   endfunction

   assign ar_hs     = bus_ar_valid & bus_ar_ready;
   assign r_hs      = bus_r_valid & bus_r_ready;
   assign out_hs    = out_valid & out_ready;
   // Each in-flight request owns a buffer slot, so R can always be accepted.
   assign credit_ok = (({1'b0, occupancy} + {1'b0, outstanding}) < (OCC_W+1)'(DEPTH))
                      && (outstanding < OCC_W'(MAX_OUT));
   assign issue     = (state == RUN) && enable && !bus_ar_valid && credit_ok && !redirect_valid;
   assign track_ar  = ar_hs && (state == RUN) && !redirect_valid;
   assign keep_beat = r_hs && (state == RUN) && !redirect_valid;
   assign outstanding_nxt = outstanding + OCC_W'(ar_hs) - OCC_W'(r_hs);

   assign bus_r_ready = (state != IDLE);
   assign out_valid   = (occupancy != '0);
   assign {out_data, out_pc} = head;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable) state_nxt = RUN;
         RUN:     if (!enable && outstanding == '0 && !bus_ar_valid) state_nxt = IDLE;
         DRAIN:   if (outstanding == '0 && !bus_ar_valid) state_nxt = enable ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
      // Anything still in flight at a redirect belongs to the old stream.
      if (redirect_valid && state != DRAIN)
         state_nxt = (outstanding_nxt != '0 || bus_ar_valid) ? DRAIN : RUN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         pc           <= '0;
         bus_ar       <= '0;
         bus_ar_valid <= 1'b0;
         outstanding  <= '0;
         pcf_wr       <= '0;
         pcf_rd       <= '0;
      end else begin
         state       <= state_nxt;
         outstanding <= outstanding_nxt;
         if (redirect_valid)
            pc <= redirect_pc;
         else if (state == IDLE)
            pc <= initial_pc;
         else if (issue)
            pc <= pc + ADDR_W'(PC_STEP);
         if (issue) begin
            bus_ar       <= pc;
            bus_ar_valid <= 1'b1;
         end else if (ar_hs) begin
            bus_ar_valid <= 1'b0;
         end
         if (redirect_valid) begin
            pcf_wr <= '0;
            pcf_rd <= '0;
         end else begin
            if (track_ar)
               pcf_wr <= pcf_inc(pcf_wr);
            if (keep_beat)
               pcf_rd <= pcf_inc(pcf_rd);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (track_ar)
         pc_fifo[pcf_wr] <= bus_ar;
   end

   ifu_line_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_line_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (keep_beat),
      .push_data ({bus_r_data, pc_fifo[pcf_rd]}),
      .pop       (out_hs),
      .flush     (redirect_valid),
      .head      (head),
      .count     (occupancy)
   );

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue with a one-cycle-latency read-bus responder.
module tb_ifu_fetch_queue;

   logic         clk;
   logic         rst;
   logic         enable;
   logic [47:0]  initial_pc;
   logic         redirect_valid;
   logic [47:0]  redirect_pc;
   logic [47:0]  bus_ar;
   logic         bus_ar_valid;
   logic         bus_ar_ready;
   logic         bus_r_valid;
   logic         bus_r_ready;
   logic [127:0] bus_r_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic [47:0]  out_pc;
   logic [2:0]   occupancy;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_ar     = 0;
   int          n_out    = 0;
   logic [47:0] exp_ar   = '0;
   logic [47:0] exp_out  = '0;
   bit          drain_chk = 1'b0;
   bit          r_hold    = 1'b0;
   bit          found;

   logic [47:0] rq[$];
   logic [47:0] ar_addr;
   bit          ar_fire;
   bit          r_fire;

   ifu_fetch_queue dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .initial_pc     (initial_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .bus_ar         (bus_ar),
      .bus_ar_valid   (bus_ar_valid),
      .bus_ar_ready   (bus_ar_ready),
      .bus_r_valid    (bus_r_valid),
      .bus_r_ready    (bus_r_ready),
      .bus_r_data     (bus_r_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_pc         (out_pc),
      .occupancy      (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] line_of(input logic [47:0] a);
      return {16'hC0DE, 64'h0, a};
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Read-bus slave: answers each accepted address with one beat a cycle later.
   initial begin
      bus_r_valid = 1'b0;
      bus_r_data  = '0;
      forever begin
         @(negedge clk);
         ar_fire = bus_ar_valid && bus_ar_ready;
         r_fire  = bus_r_valid && bus_r_ready;
         ar_addr = bus_ar;
         @(posedge clk);
         #2;
         if (rst) begin
            rq.delete();
         end else begin
            if (r_fire) rq.delete(0);
            if (ar_fire) rq.push_back(ar_addr);
         end
         bus_r_valid = !r_hold && (rq.size() != 0);
         bus_r_data  = (rq.size() != 0) ? line_of(rq[0]) : '0;
      end
   end

   task automatic run_mon(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (bus_ar_valid && bus_ar_ready) begin
            check("ar_addr", 128'(bus_ar), 128'(exp_ar));
            if (drain_chk) begin
               check("ar_after_drain", 128'(rq.size()), 128'd0);
               drain_chk = 1'b0;
            end
            exp_ar = exp_ar + 48'd1;
            n_ar++;
         end
         if (out_valid && out_ready) begin
            check("out_pc", 128'(out_pc), 128'(exp_out));
            check("out_data", out_data, line_of(exp_out));
            exp_out = exp_out + 48'd1;
            n_out++;
         end
      end
   endtask

   task automatic do_reset(input logic [47:0] ipc);
      rst = 1'b1; enable = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      out_ready = 1'b0; bus_ar_ready = 1'b1; r_hold = 1'b0; initial_pc = ipc;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      // Reset values and in-order streaming.
      rst = 1'b1; enable = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      out_ready = 1'b0; bus_ar_ready = 1'b1; r_hold = 1'b0; initial_pc = 48'h100;
      tick();
      tick();
      @(negedge clk);
      check("rst_bus_ar", 128'(bus_ar), 128'h0);
      check("rst_ar_valid", 128'(bus_ar_valid), 128'h0);
      check("rst_r_ready", 128'(bus_r_ready), 128'h0);
      check("rst_out_valid", 128'(out_valid), 128'h0);
      check("rst_out_data", out_data, 128'h0);
      check("rst_out_pc", 128'(out_pc), 128'h0);
      check("rst_occ", 128'(occupancy), 128'h0);
      tick();
      rst = 1'b0; enable = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check("s1_run_no_ar", 128'(bus_ar_valid), 128'h0);
      exp_ar = 48'h100; exp_out = 48'h100; n_ar = 0; n_out = 0;
      run_mon(30);
      check("s1_progress", 128'(n_out >= 8), 128'd1);

      // Credit limit with a stalled decoder.
      do_reset(48'h100);
      enable = 1'b1;
      exp_ar = 48'h100; n_ar = 0;
      run_mon(30);
      check("s2_ar_count", 128'(n_ar), 128'd4);
      check("s2_occ_full", 128'(occupancy), 128'd4);
      check("s2_ar_quiet", 128'(bus_ar_valid), 128'd0);
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      check("s2_head_pc", 128'(out_pc), 128'h100);
      check("s2_head_data", out_data, line_of(48'h100));
      tick();
      out_ready = 1'b0;
      n_ar = 0;
      run_mon(20);
      check("s2_one_refill", 128'(n_ar), 128'd1);
      check("s2_occ_refull", 128'(occupancy), 128'd4);

      // AR held stable while the bus stalls.
      do_reset(48'h100);
      bus_ar_ready = 1'b0; enable = 1'b1; out_ready = 1'b1;
      tick();
      @(negedge clk);
      check("s3_lat_run", 128'(bus_ar_valid), 128'd0);
      tick();
      @(negedge clk);
      check("s3_lat_ar", 128'(bus_ar_valid), 128'd1);
      check("s3_ar_pc", 128'(bus_ar), 128'h100);
      for (int i = 0; i < 5; i++) begin
         tick();
         @(negedge clk);
         check("s3_hold_vld", 128'(bus_ar_valid), 128'd1);
         check("s3_hold_addr", 128'(bus_ar), 128'h100);
      end
      tick();
      bus_ar_ready = 1'b1;
      exp_ar = 48'h100; exp_out = 48'h100; n_ar = 0; n_out = 0;
      run_mon(12);
      check("s3_out_seen", 128'(n_out >= 3), 128'd1);

      // Redirect with two requests in flight.
      do_reset(48'h100);
      r_hold = 1'b1; enable = 1'b1;
      exp_ar = 48'h100; n_ar = 0;
      run_mon(8);
      check("s4_two_out", 128'(n_ar), 128'd2);
      tick();
      redirect_valid = 1'b1; redirect_pc = 48'h200;
      tick();
      redirect_valid = 1'b0; r_hold = 1'b0;
      @(negedge clk);
      check("s4_flush_vld", 128'(out_valid), 128'd0);
      tick();
      tick();
      tick();
      @(negedge clk);
      check("s4_drop_occ", 128'(occupancy), 128'd0);
      check("s4_no_ar_drain", 128'(bus_ar_valid), 128'd0);
      drain_chk = 1'b1; exp_ar = 48'h200; exp_out = 48'h200; n_out = 0; out_ready = 1'b1;
      run_mon(12);
      check("s4_out_seen", 128'(n_out >= 1), 128'd1);
      drain_chk = 1'b0;

      // Redirect colliding with R and out handshakes.
      do_reset(48'h100);
      enable = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (bus_r_valid && bus_r_ready && out_valid) found = 1'b1;
      end
      check("s5_setup", 128'(found), 128'd1);
      redirect_valid = 1'b1; redirect_pc = 48'h280; out_ready = 1'b1;
      tick();
      redirect_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      check("s5_out_vld", 128'(out_valid), 128'd0);
      check("s5_occ", 128'(occupancy), 128'd0);
      exp_ar = 48'h280; exp_out = 48'h280; n_out = 0; out_ready = 1'b1;
      run_mon(20);
      check("s5_out_seen", 128'(n_out >= 1), 128'd1);

      // Enable dropped with two in flight, then re-enabled.
      do_reset(48'h100);
      r_hold = 1'b1; enable = 1'b1;
      exp_ar = 48'h100; n_ar = 0;
      run_mon(8);
      check("s6_two_out", 128'(n_ar), 128'd2);
      tick();
      enable = 1'b0; initial_pc = 48'h300; r_hold = 1'b0;
      tick();
      tick();
      tick();
      @(negedge clk);
      check("s6_occ", 128'(occupancy), 128'd2);
      check("s6_idle_r_rdy", 128'(bus_r_ready), 128'd0);
      check("s6_no_ar", 128'(bus_ar_valid), 128'd0);
      check("s6_head_pc", 128'(out_pc), 128'h100);
      check("s6_head_data", out_data, line_of(48'h100));
      tick();
      enable = 1'b1;
      tick();
      tick();
      @(negedge clk);
      check("s6_re_ar_vld", 128'(bus_ar_valid), 128'd1);
      check("s6_re_ar_pc", 128'(bus_ar), 128'h300);
      check("s6_kept_pc", 128'(out_pc), 128'h100);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
